// File: rtl/regfile_write_bank_pkg.sv
// Shared constants and types for the register-file write bank.
// Register 0 is architecturally zero, so it never gets storage or a busy bit.
package regfile_write_bank_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 1 << ADDR_W;
    localparam int FIFO_D    = 2;
    localparam int PTR_W     = 1;
    localparam int CNT_W     = 2;
    localparam int R0        = 0;

    localparam logic [REG_COUNT-1:0] R0_MASK = {{(REG_COUNT-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/regfile_write_bank_decoder_32.sv
// Address-to-one-hot decoder with enable: the inverse of the 32:1 read mux.
module regfile_write_bank_decoder_32
    import regfile_write_bank_pkg::*;
(
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 en,
    output logic [REG_COUNT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the 32x32 register file: a 2-deep request buffer retiring
// one register write per cycle, plus in-flight (busy) tracking for hazards.
module regfile_write_bank
    import regfile_write_bank_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          drain_en,
    output logic [REG_COUNT*DATA_W-1:0]   regs_flat,
    output logic [REG_COUNT-1:0]          busy_mask,
    output logic [CNT_W-1:0]              count
);

    wr_entry_t                      fifo_q [FIFO_D];
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic                           push;
    logic                           pop;
    logic [FIFO_D-1:0]              entry_valid;
    logic [REG_COUNT-1:0]           entry_onehot [FIFO_D];
    logic [REG_COUNT-1:0]           retire_onehot;
    wr_entry_t                      head;
    logic [REG_COUNT-1:1][DATA_W-1:0] regs_q;

    // A full buffer refuses new requests even if it pops this cycle.
    assign wr_ready = reset && (count != CNT_W'(FIFO_D));
    assign push     = wr_valid && wr_ready;
    assign pop      = drain_en && (count != '0);
    assign head     = fifo_q[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= {wr_addr, wr_data};
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < FIFO_D; i++) begin
            entry_valid[i] = (count == CNT_W'(FIFO_D)) ||
                             ((count == CNT_W'(1)) && (rd_ptr == PTR_W'(i)));
        end
    end

    for (genvar g = 0; g < FIFO_D; g++) begin : g_busy_dec
        regfile_write_bank_decoder_32 u_busy_dec (
            .addr   (fifo_q[g].addr),
            .en     (entry_valid[g]),
            .onehot (entry_onehot[g])
        );
    end

    assign busy_mask = (entry_onehot[0] | entry_onehot[1]) & ~R0_MASK;

    regfile_write_bank_decoder_32 u_retire_dec (
        .addr   (head.addr),
        .en     (pop),
        .onehot (retire_onehot)
    );

    // Slot 0 of the decode has no register behind it, so an r0 write is a no-op.
    always_ff @(posedge clock) begin
        if (!reset) begin
            regs_q <= '0;
        end else begin
            for (int k = 1; k < REG_COUNT; k++) begin
                if (retire_onehot[k]) begin
                    regs_q[k] <= head.data;
                end
            end
        end
    end

    assign regs_flat = {regs_q, {DATA_W{1'b0}}};

endmodule
